// File: rtl/parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// parking_gate_arbiter
//
// Purpose:
//   Arbitrates one parking barrier between an entry lane and an exit lane.
//   It grants the gate round-robin when both lanes are eligible, keeps the
//   gate open until a car passes or a timeout expires, holds it closed for a
//   fixed number of cycles, and tracks the car-park occupancy.
//
// Parameters:
//   CAPACITY      maximum occupancy (1..255)
//   OPEN_TIMEOUT  cycles the gate stays open waiting for a pass (>= 2)
//   CLOSE_HOLD    cycles the gate stays closed before the next grant (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   entry_req    level, car waiting at the entry sensor
//   exit_req     level, car waiting at the exit sensor
//   pass         one-cycle pulse, the car has cleared the barrier
//   gate_open    barrier drive (1 = open), registered
//   grant_entry  entry lane owns the gate, registered
//   grant_exit   exit lane owns the gate, registered
//   count        current occupancy, registered
//   full         count == CAPACITY (decoded from registered count)
//   empty        count == 0 (decoded from registered count)
//   timeout_err  one-cycle pulse when an open gate expires without a pass
// -----------------------------------------------------------------------------
module parking_gate_arbiter #(
    parameter int CAPACITY     = 20,
    parameter int OPEN_TIMEOUT = 1000,
    parameter int CLOSE_HOLD   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       pass,
    output logic       gate_open,
    output logic       grant_entry,
    output logic       grant_exit,
    output logic [7:0] count,
    output logic       full,
    output logic       empty,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OPEN_ENTRY = 2'd1,
        OPEN_EXIT  = 2'd2,
        CLOSING    = 2'd3
    } state_t;

    // One timer is shared by the OPEN and CLOSING states, so it is sized
    // for the longer of the two intervals.
    localparam int TMAX = (OPEN_TIMEOUT > CLOSE_HOLD) ? OPEN_TIMEOUT : CLOSE_HOLD;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_TIMEOUT - 1);
    localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_HOLD - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [7:0]    CAP_C      = 8'(CAPACITY);

    // Saturating occupancy increment: never exceeds the capacity.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        if (value >= CAP_C) begin
            sat_inc = CAP_C;
        end else begin
            sat_inc = value + 8'd1;
        end
    endfunction

    // Saturating occupancy decrement: never goes below zero.
    function automatic logic [7:0] sat_dec(input logic [7:0] value);
        if (value == 8'd0) begin
            sat_dec = 8'd0;
        end else begin
            sat_dec = value - 8'd1;
        end
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    count_q, count_d;
    logic          last_exit_q, last_exit_d;   // 1: exit lane was served last
    logic          gate_open_q, gate_open_d;
    logic          grant_entry_q, grant_entry_d;
    logic          grant_exit_q, grant_exit_d;
    logic          timeout_err_q, timeout_err_d;
    logic          entry_ok_s;
    logic          exit_ok_s;

    assign count       = count_q;
    assign full        = (count_q == CAP_C);
    assign empty       = (count_q == 8'd0);
    assign gate_open   = gate_open_q;
    assign grant_entry = grant_entry_q;
    assign grant_exit  = grant_exit_q;
    assign timeout_err = timeout_err_q;

    // Lane eligibility from the current requests and registered occupancy.
    always_comb begin
        entry_ok_s = entry_req && !full;
        exit_ok_s  = exit_req && !empty;
    end

    // Next-state, timer, occupancy and output decode.
    // Outputs are computed for the state being entered so that the
    // registered grant/gate appear the cycle after the deciding edge.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        count_d       = count_q;
        last_exit_d   = last_exit_q;
        gate_open_d   = 1'b0;
        grant_entry_d = 1'b0;
        grant_exit_d  = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = {TW{1'b0}};
                // On a tie the lane not served last wins.
                if (entry_ok_s && (!exit_ok_s || last_exit_q)) begin
                    state_d       = OPEN_ENTRY;
                    grant_entry_d = 1'b1;
                    gate_open_d   = 1'b1;
                    last_exit_d   = 1'b0;
                end else if (exit_ok_s) begin
                    state_d      = OPEN_EXIT;
                    grant_exit_d = 1'b1;
                    gate_open_d  = 1'b1;
                    last_exit_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            OPEN_ENTRY: begin
                // A pass on the final open cycle takes priority over timeout.
                if (pass) begin
                    count_d = sat_inc(count_q);
                    state_d = CLOSING;
                    timer_d = {TW{1'b0}};
                end else if (timer_q == OPEN_LAST) begin
                    state_d       = CLOSING;
                    timer_d       = {TW{1'b0}};
                    timeout_err_d = 1'b1;
                end else begin
                    timer_d       = timer_q + TIMER_ONE;
                    grant_entry_d = 1'b1;
                    gate_open_d   = 1'b1;
                end
            end

            OPEN_EXIT: begin
                if (pass) begin
                    count_d = sat_dec(count_q);
                    state_d = CLOSING;
                    timer_d = {TW{1'b0}};
                end else if (timer_q == OPEN_LAST) begin
                    state_d       = CLOSING;
                    timer_d       = {TW{1'b0}};
                    timeout_err_d = 1'b1;
                end else begin
                    timer_d      = timer_q + TIMER_ONE;
                    grant_exit_d = 1'b1;
                    gate_open_d  = 1'b1;
                end
            end

            CLOSING: begin
                // Requests are not latched here; IDLE re-samples the levels.
                if (timer_q == CLOSE_LAST) begin
                    state_d = IDLE;
                    timer_d = {TW{1'b0}};
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = {TW{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= {TW{1'b0}};
            count_q       <= 8'd0;
            last_exit_q   <= 1'b1;
            gate_open_q   <= 1'b0;
            grant_entry_q <= 1'b0;
            grant_exit_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            count_q       <= count_d;
            last_exit_q   <= last_exit_d;
            gate_open_q   <= gate_open_d;
            grant_entry_q <= grant_entry_d;
            grant_exit_q  <= grant_exit_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_arbiter
//
// Self-checking bench for parking_gate_arbiter with CAPACITY=2,
// OPEN_TIMEOUT=8, CLOSE_HOLD=3. Each driven cycle runs a behavioural model
// of the gate, pushes the expected output vector into a scoreboard queue,
// and the vector is popped and compared just after the rising edge.
// -----------------------------------------------------------------------------
module tb_parking_gate_arbiter;

    localparam int CAP = 2;
    localparam int OT  = 8;
    localparam int CH  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       entry_req;
    logic       exit_req;
    logic       pass;
    logic       gate_open;
    logic       grant_entry;
    logic       grant_exit;
    logic [7:0] count;
    logic       full;
    logic       empty;
    logic       timeout_err;

    parking_gate_arbiter #(
        .CAPACITY     (CAP),
        .OPEN_TIMEOUT (OT),
        .CLOSE_HOLD   (CH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .pass        (pass),
        .gate_open   (gate_open),
        .grant_entry (grant_entry),
        .grant_exit  (grant_exit),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: {gate, grant_entry, grant_exit, timeout, full, empty, count}
    logic [13:0] exp_q[$];

    int n_vec    = 0;
    int n_err    = 0;
    int open_cnt = 0;
    int to_cnt   = 0;

    // Model state: 0 idle, 1 open-entry, 2 open-exit, 3 closing.
    // 'm_left' counts down the cycles remaining in the current open/closing phase.
    int   m_st     = 0;
    int   m_left   = 0;
    int   m_cnt    = 0;
    logic m_last_x = 1'b1;
    logic m_gate   = 1'b0;
    logic m_ge     = 1'b0;
    logic m_gx     = 1'b0;
    logic m_to     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one rising edge with the given inputs.
    task automatic model_step(input logic r, input logic er, input logic xr, input logic ps);
        logic can_e;
        logic can_x;
        m_to = 1'b0;
        if (r) begin
            m_st = 0; m_left = 0; m_cnt = 0; m_last_x = 1'b1;
            m_gate = 1'b0; m_ge = 1'b0; m_gx = 1'b0;
        end else if (m_st == 0) begin
            can_e = er && (m_cnt != CAP);
            can_x = xr && (m_cnt != 0);
            if (can_e && can_x) begin
                can_e = m_last_x;
                can_x = !m_last_x;
            end
            if (can_e) begin
                m_st = 1; m_left = OT; m_last_x = 1'b0;
                m_gate = 1'b1; m_ge = 1'b1;
            end else if (can_x) begin
                m_st = 2; m_left = OT; m_last_x = 1'b1;
                m_gate = 1'b1; m_gx = 1'b1;
            end
        end else if (m_st == 1 || m_st == 2) begin
            if (ps || m_left == 1) begin
                if (ps && m_st == 1 && m_cnt < CAP) m_cnt++;
                if (ps && m_st == 2 && m_cnt > 0) m_cnt--;
                m_to = !ps;
                m_st = 3; m_left = CH;
                m_gate = 1'b0; m_ge = 1'b0; m_gx = 1'b0;
            end else begin
                m_left--;
            end
        end else begin
            if (m_left == 1) m_st = 0;
            else m_left--;
        end
    endtask

    // Drive n cycles of constant inputs; check every cycle against the model.
    task automatic cyc(input logic r, input logic er, input logic xr, input logic ps, input int n);
        logic [13:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = r; entry_req = er; exit_req = xr; pass = ps;
            model_step(r, er, xr, ps);
            exp_q.push_back({m_gate, m_ge, m_gx, m_to, (m_cnt == CAP), (m_cnt == 0), 8'(m_cnt)});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("outputs", {18'd0, gate_open, grant_entry, grant_exit, timeout_err, full, empty, count},
                {18'd0, e});
            if (gate_open) open_cnt++;
            if (timeout_err) to_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0; pass = 1'b0;

        // Reset state.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2);
        chk("reset_empty", {31'd0, empty}, 32'd1);

        // Single entry: grant at edge 1, pass at edge 4, then closing.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4);
        chk("single_entry_count", {24'd0, count}, 32'd1);

        // Second entry fills the park.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4);

        // Full blocking, then exit with pass frees a space.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4);
        chk("full_no_grant", {31'd0, gate_open}, 32'd0);
        chk("full_flag", {31'd0, full}, 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1);
        chk("exit_when_full", {31'd0, grant_exit}, 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1);
        chk("after_exit_full", {31'd0, full}, 32'd0);

        // Tie at count=1 with exit served last: entry wins, then exit.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4);
        chk("tie_entry_first", {31'd0, grant_entry}, 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4);
        chk("rr_exit_next", {31'd0, grant_exit}, 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1);
        chk("rr_count", {24'd0, count}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4);

        // Timeout: gate open exactly OT cycles, one timeout pulse.
        open_cnt = 0; to_cnt = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, OT + CH + 1);
        chk("timeout_open_cycles", 32'(open_cnt), 32'(OT));
        chk("timeout_pulses", 32'(to_cnt), 32'd1);
        chk("timeout_count", {24'd0, count}, 32'd1);

        // Pass on the final open cycle wins over the timeout.
        open_cnt = 0; to_cnt = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, OT - 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, CH + 1);
        chk("collision_open_cycles", 32'(open_cnt), 32'(OT));
        chk("collision_pulses", 32'(to_cnt), 32'd0);
        chk("collision_count", {24'd0, count}, 32'd2);

        // Reset during OPEN_EXIT aborts with no count update and no pulse.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3);
        chk("open_exit_before_rst", {31'd0, grant_exit}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1);
        chk("rst_gate", {31'd0, gate_open}, 32'd0);
        chk("rst_count", {24'd0, count}, 32'd0);

        // Empty blocking plus spurious passes in IDLE.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 5);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2);
        chk("empty_no_grant", {31'd0, gate_open}, 32'd0);
        chk("empty_count", {24'd0, count}, 32'd0);

        // Pass during CLOSING is ignored.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, CH + 1);
        chk("closing_pass_ignored", {24'd0, count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
